// File: rtl/smem_bank_scheduler.sv
// Purpose: splits one multi-lane shared-memory request batch into bank-conflict-free passes (same-address reads broadcast).
// Latency: first pass is visible the cycle after acceptance, then one pass per cycle; the next batch is taken on the last fire.
// Backpressure: bank_req_ready=0 holds every bank_* output stable; core_req_ready stays low until the last pass fires.
// Optional perf counters are enabled with `define SMEM_SCHED_PERF_EN.
module smem_bank_scheduler #(
  parameter int NUM_REQS         = 4,
  parameter int NUM_BANKS        = 4,
  parameter int WORD_SIZE        = 4,
  parameter int ADDR_WIDTH       = 30,
  parameter int TAG_WIDTH        = 8,
  parameter int BANK_ADDR_OFFSET = 0,
  localparam int BANK_BITS = $clog2(NUM_BANKS),
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1,
  localparam int LINE_W    = ADDR_WIDTH - BANK_BITS,
  localparam int DATA_W    = WORD_SIZE * 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQS-1:0]               core_req_valid,
  input  logic [NUM_REQS-1:0]               core_req_rw,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]    core_req_addr,
  input  logic [NUM_REQS*WORD_SIZE-1:0]     core_req_byteen,
  input  logic [NUM_REQS*DATA_W-1:0]        core_req_data,
  input  logic [TAG_WIDTH-1:0]              core_req_tag,
  output logic                              core_req_ready,
  output logic [NUM_BANKS-1:0]              bank_req_valid,
  output logic [NUM_BANKS-1:0]              bank_req_rw,
  output logic [NUM_BANKS*LINE_W-1:0]       bank_req_addr,
  output logic [NUM_BANKS*WORD_SIZE-1:0]    bank_req_byteen,
  output logic [NUM_BANKS*DATA_W-1:0]       bank_req_data,
  output logic [NUM_BANKS*NUM_REQS-1:0]     bank_req_lanes,
  output logic [TAG_WIDTH-1:0]              bank_req_tag,
  output logic                              bank_req_last,
  input  logic                              bank_req_ready
`ifdef SMEM_SCHED_PERF_EN
  ,
  output logic [43:0]                       perf_batches,
  output logic [43:0]                       perf_conflict_passes,
  output logic [43:0]                       perf_stall_cycles
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((64'd1 << BANK_ADDR_OFFSET) - 64'd1);

  typedef enum logic [0:0] {S_IDLE, S_ISSUE} state_t;

  state_t                         r_state, w_state_nxt;
  logic [NUM_REQS-1:0]            r_pending, w_pending_nxt;
  logic [NUM_REQS-1:0]            r_rw;
  logic [NUM_REQS*ADDR_WIDTH-1:0] r_addr;
  logic [NUM_REQS*WORD_SIZE-1:0]  r_byteen;
  logic [NUM_REQS*DATA_W-1:0]     r_data;
  logic [TAG_WIDTH-1:0]           r_tag;

  logic                           w_any_valid;
  logic                           w_fire;
  logic                           w_core_ready;
  logic                           w_accept;
  logic [NUM_REQS-1:0]            w_cover;

  function automatic logic [BANK_W-1:0] f_bank(input logic [ADDR_WIDTH-1:0] a);
    return BANK_W'((a >> BANK_ADDR_OFFSET) & ADDR_WIDTH'(NUM_BANKS - 1));
  endfunction

  // Line address = address with the bank-select field squeezed out.
  function automatic logic [LINE_W-1:0] f_line(input logic [ADDR_WIDTH-1:0] a);
    return LINE_W'(((a >> (BANK_ADDR_OFFSET + BANK_BITS)) << BANK_ADDR_OFFSET) | (a & LOW_MASK));
  endfunction

  // Per bank: pick the lowest pending lane as leader and fold identical-address reads into its pass.
  always_comb begin : pass_select
    logic                  w_found;
    logic [NUM_REQS-1:0]   w_lead_oh;
    logic                  w_lead_rw;
    logic [ADDR_WIDTH-1:0] w_lead_addr;
    logic [WORD_SIZE-1:0]  w_lead_be;
    logic [DATA_W-1:0]     w_lead_data;
    bank_req_valid  = '0;
    bank_req_rw     = '0;
    bank_req_addr   = '0;
    bank_req_byteen = '0;
    bank_req_data   = '0;
    bank_req_lanes  = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_found     = 1'b0;
      w_lead_oh   = '0;
      w_lead_rw   = 1'b0;
      w_lead_addr = '0;
      w_lead_be   = '0;
      w_lead_data = '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!w_found && r_pending[i] &&
            (f_bank(r_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) == BANK_W'(b))) begin
          w_found      = 1'b1;
          w_lead_oh[i] = 1'b1;
          w_lead_rw    = r_rw[i];
          w_lead_addr  = r_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
          w_lead_be    = r_byteen[i*WORD_SIZE +: WORD_SIZE];
          w_lead_data  = r_data[i*DATA_W +: DATA_W];
        end
      end
      // A reset cycle issues nothing, so a dropped batch never shows a last pass.
      if (w_found && !reset) begin
        bank_req_valid[b]                       = 1'b1;
        bank_req_rw[b]                          = w_lead_rw;
        bank_req_addr[b*LINE_W +: LINE_W]       = f_line(w_lead_addr);
        bank_req_byteen[b*WORD_SIZE +: WORD_SIZE] = w_lead_be;
        bank_req_data[b*DATA_W +: DATA_W]       = w_lead_data;
        for (int j = 0; j < NUM_REQS; j++) begin
          if (r_pending[j] &&
              (w_lead_oh[j] ||
               (!w_lead_rw && !r_rw[j] &&
                (r_addr[j*ADDR_WIDTH +: ADDR_WIDTH] == w_lead_addr)))) begin
            bank_req_lanes[b*NUM_REQS + j] = 1'b1;
          end
        end
      end
    end
  end

  // Union of lanes served by the current pass across all banks.
  always_comb begin
    w_cover = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_cover = w_cover | bank_req_lanes[b*NUM_REQS +: NUM_REQS];
    end
  end

  assign w_any_valid    = |bank_req_valid;
  assign w_fire         = w_any_valid & bank_req_ready;
  assign bank_req_last  = w_any_valid & (w_cover == r_pending);
  assign bank_req_tag   = r_tag;
  assign w_core_ready   = ~reset & ((r_state == S_IDLE) | (w_fire & bank_req_last));
  assign core_req_ready = w_core_ready;
  assign w_accept       = (|core_req_valid) & w_core_ready;

  // Next state: retire the fired lanes, then a new batch (only possible on the last fire) overwrites pending.
  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    if (w_fire) begin
      w_pending_nxt = r_pending & ~w_cover;
    end
    if (w_accept) begin
      w_pending_nxt = core_req_valid;
    end
    w_state_nxt = (w_pending_nxt != '0) ? S_ISSUE : S_IDLE;
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_tag     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      if (w_accept) begin
        r_tag <= core_req_tag;
      end
    end
  end

  // Lane payload capture; only meaningful under a pending bit, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rw     <= core_req_rw;
      r_addr   <= core_req_addr;
      r_byteen <= core_req_byteen;
      r_data   <= core_req_data;
    end
  end

`ifdef SMEM_SCHED_PERF_EN
  logic r_first_pass;

  // Performance counters: batches taken, non-first passes fired, stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_first_pass         <= 1'b0;
      perf_batches         <= '0;
      perf_conflict_passes <= '0;
      perf_stall_cycles    <= '0;
    end else begin
      if (w_fire && !r_first_pass) begin
        perf_conflict_passes <= perf_conflict_passes + 44'd1;
      end
      if (w_fire) begin
        r_first_pass <= 1'b0;
      end
      if (w_accept) begin
        r_first_pass <= 1'b1;
        perf_batches <= perf_batches + 44'd1;
      end
      if (w_any_valid && !bank_req_ready) begin
        perf_stall_cycles <= perf_stall_cycles + 44'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_smem_bank_scheduler.sv
// Bench for smem_bank_scheduler: a per-bank grouping model predicts every pass, a scoreboard compares each cycle,
// and directed batches carry hand-computed literal expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
module tb_smem_bank_scheduler;

  localparam int NR = 4;
  localparam int NB = 4;
  localparam int WS = 4;
  localparam int AW = 30;
  localparam int TW = 8;
  localparam int DW = WS * 8;
  localparam int LW = AW - 2;

  logic              clk;
  logic              reset;
  logic [NR-1:0]     core_req_valid;
  logic [NR-1:0]     core_req_rw;
  logic [NR*AW-1:0]  core_req_addr;
  logic [NR*WS-1:0]  core_req_byteen;
  logic [NR*DW-1:0]  core_req_data;
  logic [TW-1:0]     core_req_tag;
  logic              core_req_ready;
  logic [NB-1:0]     bank_req_valid;
  logic [NB-1:0]     bank_req_rw;
  logic [NB*LW-1:0]  bank_req_addr;
  logic [NB*WS-1:0]  bank_req_byteen;
  logic [NB*DW-1:0]  bank_req_data;
  logic [NB*NR-1:0]  bank_req_lanes;
  logic [TW-1:0]     bank_req_tag;
  logic              bank_req_last;
  logic              bank_req_ready;
`ifdef SMEM_SCHED_PERF_EN
  logic [43:0]       perf_batches, perf_conflict_passes, perf_stall_cycles;
`endif

  smem_bank_scheduler dut (
    .clk             (clk),
    .reset           (reset),
    .core_req_valid  (core_req_valid),
    .core_req_rw     (core_req_rw),
    .core_req_addr   (core_req_addr),
    .core_req_byteen (core_req_byteen),
    .core_req_data   (core_req_data),
    .core_req_tag    (core_req_tag),
    .core_req_ready  (core_req_ready),
    .bank_req_valid  (bank_req_valid),
    .bank_req_rw     (bank_req_rw),
    .bank_req_addr   (bank_req_addr),
    .bank_req_byteen (bank_req_byteen),
    .bank_req_data   (bank_req_data),
    .bank_req_lanes  (bank_req_lanes),
    .bank_req_tag    (bank_req_tag),
    .bank_req_last   (bank_req_last),
    .bank_req_ready  (bank_req_ready)
`ifdef SMEM_SCHED_PERF_EN
    ,
    .perf_batches         (perf_batches),
    .perf_conflict_passes (perf_conflict_passes),
    .perf_stall_cycles    (perf_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model: expected pass queue ----------------
  typedef struct packed {
    logic [NB-1:0]    valid;
    logic [NB-1:0]    rw;
    logic [NB*NR-1:0] lanes;
    logic [NB*LW-1:0] addr;
    logic [NB*WS-1:0] byteen;
    logic [NB*DW-1:0] data;
    logic [TW-1:0]    tag;
    logic             last;
  } pass_t;

  pass_t q[$];

  // Each bank serves its lanes as an ordered list of groups; a read joins an earlier read group
  // with the same address, anything else opens a new group. Pass k = k-th group of every bank.
  task automatic push_batch(input logic [NR-1:0] v, input logic [NR-1:0] rw, input logic [NR*AW-1:0] a,
                            input logic [NR*WS-1:0] be, input logic [NR*DW-1:0] d, input logic [TW-1:0] tag);
    int            ng[NB];
    int            gl[NB][NR];
    logic [NR-1:0] gm[NB][NR];
    int            np;
    int            b;
    int            ld;
    bit            joined;
    logic [AW-1:0] ai;
    pass_t         p;
    np = 0;
    for (int x = 0; x < NB; x++) begin
      ng[x] = 0;
      for (int y = 0; y < NR; y++) begin gl[x][y] = 0; gm[x][y] = '0; end
    end
    for (int i = 0; i < NR; i++) begin
      if (v[i]) begin
        ai = a[i*AW +: AW];
        b = int'(ai % NB);
        joined = 1'b0;
        if (!rw[i]) begin
          for (int k = 0; k < ng[b]; k++) begin
            if (!joined && !rw[gl[b][k]] && a[gl[b][k]*AW +: AW] == ai) begin
              gm[b][k][i] = 1'b1;
              joined = 1'b1;
            end
          end
        end
        if (!joined) begin
          gl[b][ng[b]] = i;
          gm[b][ng[b]] = NR'(1) << i;
          ng[b]++;
        end
      end
    end
    for (int x = 0; x < NB; x++) if (ng[x] > np) np = ng[x];
    for (int k = 0; k < np; k++) begin
      p = '0;
      for (int x = 0; x < NB; x++) begin
        if (k < ng[x]) begin
          ld = gl[x][k];
          p.valid[x]            = 1'b1;
          p.rw[x]               = rw[ld];
          p.lanes[x*NR +: NR]   = gm[x][k];
          p.addr[x*LW +: LW]    = LW'(a[ld*AW +: AW] / NB);
          p.byteen[x*WS +: WS]  = be[ld*WS +: WS];
          p.data[x*DW +: DW]    = d[ld*DW +: DW];
        end
      end
      p.tag  = tag;
      p.last = (k == np - 1);
      q.push_back(p);
    end
  endtask

  // Scoreboard: compare DUT outputs with the head of the model queue every cycle.
  always @(negedge clk) begin : scoreboard
    pass_t            e;
    logic             exp_rdy;
    logic [NB*LW-1:0] m_addr;
    logic [NB*WS-1:0] m_be;
    logic [NB*DW-1:0] m_data;
    if (reset) begin
      chk(bank_req_valid == '0 && core_req_ready == 1'b0, "sb_reset_outputs",
          {bank_req_valid, core_req_ready}, 0);
      q.delete();
    end else begin
      if (q.size() == 0) begin
        exp_rdy = 1'b1;
        chk(bank_req_valid == '0, "sb_idle_valid", bank_req_valid, 0);
      end else begin
        e = q[0];
        exp_rdy = bank_req_ready && e.last;
        for (int x = 0; x < NB; x++) begin
          m_addr[x*LW +: LW] = {LW{e.valid[x]}};
          m_be[x*WS +: WS]   = {WS{e.valid[x]}};
          m_data[x*DW +: DW] = {DW{e.valid[x]}};
        end
        chk(bank_req_valid == e.valid, "sb_valid", bank_req_valid, e.valid);
        chk(bank_req_lanes == e.lanes, "sb_lanes", bank_req_lanes, e.lanes);
        chk(bank_req_tag == e.tag, "sb_tag", bank_req_tag, e.tag);
        chk(bank_req_last == e.last, "sb_last", bank_req_last, e.last);
        chk((bank_req_addr & m_addr) == e.addr, "sb_addr", bank_req_addr & m_addr, e.addr);
        chk((bank_req_data & m_data) == e.data, "sb_data", bank_req_data & m_data, e.data);
        chk({bank_req_rw & e.valid, bank_req_byteen & m_be} == {e.rw, e.byteen}, "sb_rw_be",
            {bank_req_rw & e.valid, bank_req_byteen & m_be}, {e.rw, e.byteen});
      end
      chk(core_req_ready == exp_rdy, "sb_core_ready", core_req_ready, exp_rdy);
      if (q.size() > 0 && bank_req_ready) void'(q.pop_front());
      if ((|core_req_valid) && exp_rdy)
        push_batch(core_req_valid, core_req_rw, core_req_addr, core_req_byteen, core_req_data, core_req_tag);
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [NR-1:0] v, input logic [NR-1:0] rw,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [AW-1:0] a3, input logic [TW-1:0] tag);
    core_req_valid = v;
    core_req_rw    = rw;
    core_req_addr  = {a3, a2, a1, a0};
    core_req_tag   = tag;
    for (int i = 0; i < NR; i++) begin
      core_req_byteen[i*WS +: WS] = WS'(i + 1);
      core_req_data[i*DW +: DW]   = {tag, 8'(i), 16'hBEEF};
    end
  endtask

  // Called 1 ns after a rising edge with a batch driven; returns 1 ns after the accepting edge.
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!core_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk(n < 50, "accept_timeout", 128'(n), 50);
    @(posedge clk);
    #1;
    core_req_valid = '0;
  endtask

  pass_t snap, cur;

  initial begin
    reset = 1'b1;
    bank_req_ready = 1'b1;
    drive('0, '0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    chk(core_req_ready == 1'b0, "reset_core_ready", core_req_ready, 0);
    chk(bank_req_valid == '0, "reset_bank_valid", bank_req_valid, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk(core_req_ready == 1'b1 && bank_req_valid == '0, "idle_after_reset",
        {core_req_ready, bank_req_valid}, 5'b10000);
    @(posedge clk); #1;

    // Conflict-free reads, one lane per bank.
    drive(4'b1111, 4'b0000, 0, 1, 2, 3, 8'h01);
    wait_accept();
    @(negedge clk);
    chk(bank_req_valid == 4'b1111, "t1_valid", bank_req_valid, 4'b1111);
    chk(bank_req_lanes == 16'h8421, "t1_lanes", bank_req_lanes, 16'h8421);
    chk(bank_req_addr == '0 && bank_req_last && core_req_ready, "t1_addr_last_ready",
        {bank_req_addr, bank_req_last, core_req_ready}, 2'b11);
    @(posedge clk); #1;

    // Four writes all on bank0: four serial passes.
    drive(4'b1111, 4'b1111, 0, 4, 8, 12, 8'h02);
    wait_accept();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk(bank_req_lanes == 16'(1 << k), "t2_lanes", bank_req_lanes, 16'(1 << k));
      chk(bank_req_addr[LW-1:0] == LW'(k), "t2_line", bank_req_addr[LW-1:0], k);
      chk(bank_req_last == (k == 3) && core_req_ready == (k == 3), "t2_last_ready",
          {bank_req_last, core_req_ready}, {2{k == 3}});
    end
    @(posedge clk); #1;

    // All lanes read address 5: one broadcast pass on bank1.
    drive(4'b1111, 4'b0000, 5, 5, 5, 5, 8'h03);
    wait_accept();
    @(negedge clk);
    chk(bank_req_valid == 4'b0010 && bank_req_lanes == 16'h00F0, "t3_broadcast",
        {bank_req_valid, bank_req_lanes}, {4'b0010, 16'h00F0});
    chk(bank_req_addr[2*LW-1:LW] == LW'(1) && bank_req_last, "t3_line_last",
        {bank_req_addr[2*LW-1:LW], bank_req_last}, {LW'(1), 1'b1});
    @(posedge clk); #1;

    // Conflict batch with a 3-cycle stall on pass 2.
    drive(4'b1111, 4'b1111, 0, 4, 8, 12, 8'h04);
    wait_accept();
    @(negedge clk);
    chk(bank_req_lanes == 16'h0001, "t4_pass1", bank_req_lanes, 16'h0001);
    @(posedge clk); #1;
    bank_req_ready = 1'b0;
    @(negedge clk);
    snap = {bank_req_valid, bank_req_rw, bank_req_lanes, bank_req_addr, bank_req_byteen,
            bank_req_data, bank_req_tag, bank_req_last};
    chk(bank_req_lanes == 16'h0002 && core_req_ready == 1'b0, "t4_pass2_stalled",
        {bank_req_lanes, core_req_ready}, {16'h0002, 1'b0});
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        @(posedge clk); #1;
        bank_req_ready = 1'b1;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
      cur = {bank_req_valid, bank_req_rw, bank_req_lanes, bank_req_addr, bank_req_byteen,
             bank_req_data, bank_req_tag, bank_req_last};
      chk(cur == snap, "t4_hold_stable", cur.lanes, snap.lanes);
    end
    @(negedge clk);
    chk(bank_req_lanes == 16'h0004, "t4_pass3", bank_req_lanes, 16'h0004);
    @(negedge clk);
    chk(bank_req_lanes == 16'h0008 && bank_req_last, "t4_pass4_last",
        {bank_req_lanes, bank_req_last}, {16'h0008, 1'b1});
    @(posedge clk); #1;

    // Mixed read/write merge: reads of 5 on lanes 0,1; write lane 2; read of 9 on lane 3.
    drive(4'b1111, 4'b0100, 5, 5, 5, 9, 8'h05);
    wait_accept();
    @(negedge clk);
    chk(bank_req_lanes == 16'h0030 && bank_req_rw == 4'b0000, "t5_mixed_pass1",
        {bank_req_lanes, bank_req_rw}, {16'h0030, 4'b0000});
    repeat (3) @(negedge clk);
    @(posedge clk); #1;

    // Back-to-back: tag 0x22 taken on the last fire of tag 0x11.
    drive(4'b0011, 4'b0011, 0, 4, 0, 0, 8'h11);
    wait_accept();
    drive(4'b0001, 4'b0000, 3, 0, 0, 0, 8'h22);
    @(negedge clk);
    chk(core_req_ready == 1'b0 && bank_req_tag == 8'h11, "t6_first_pass",
        {core_req_ready, bank_req_tag}, {1'b0, 8'h11});
    @(negedge clk);
    chk(core_req_ready && bank_req_last && bank_req_tag == 8'h11, "t6_last_fire_accept",
        {core_req_ready, bank_req_last, bank_req_tag}, {2'b11, 8'h11});
    @(posedge clk); #1;
    core_req_valid = '0;
    @(negedge clk);
    chk(bank_req_tag == 8'h22 && bank_req_valid == 4'b1000, "t6_no_bubble",
        {bank_req_tag, bank_req_valid}, {8'h22, 4'b1000});
    @(posedge clk); #1;

    // Same-address writes on lanes 0 and 2, reset after the first pass.
    drive(4'b0101, 4'b0101, 8, 1, 8, 1, 8'h33);
    wait_accept();
    @(negedge clk);
    chk(bank_req_lanes == 16'h0001 && bank_req_addr[LW-1:0] == LW'(2) && !bank_req_last, "t7_pass1",
        {bank_req_lanes, bank_req_addr[LW-1:0], bank_req_last}, {16'h0001, LW'(2), 1'b0});
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk(bank_req_valid == '0 && !bank_req_last && !core_req_ready, "t7_reset_drop",
        {bank_req_valid, bank_req_last, core_req_ready}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk(bank_req_valid == '0 && core_req_ready, "t7_idle_after_reset",
        {bank_req_valid, core_req_ready}, 5'b00001);
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
